// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX-stage issue logic and the HI/LO mul/div unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply / divide / multiply-accumulate unit owning the HI/LO pair.
// One shift-add or restoring shift-subtract step per clock, sign fix-up at the end.
//
// state  | meaning
// S_IDLE | waiting for a request; MTHI/MTLO complete here in one edge
// S_RUN  | WIDTH iteration steps on the magnitudes
// S_FIX  | sign correction, accumulate, commit HI/LO, pulse done
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [1:0] K_MUL  = 2'd0;
  localparam logic [1:0] K_DIV  = 2'd1;
  localparam logic [1:0] K_MADD = 2'd2;
  localparam logic [1:0] K_MSUB = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       kind_q, kind_d;
  logic [WIDTH-1:0] oper_q, oper_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // Operand magnitudes at accept; unsigned ops (odd codes) never negate.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign sign_a = !bus.op[0] && bus.a[WIDTH-1];
  assign sign_b = !bus.op[0] && bus.b[WIDTH-1];
  assign abs_a  = sign_a ? -bus.a : bus.a;
  assign abs_b  = sign_b ? -bus.b : bus.b;

  // Multiply step: {work_hi, work_lo} is the partial product with the multiplier
  // shifting out of work_lo's bottom bit.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;

  assign mul_addend = work_lo_q[0] ? oper_q : '0;
  assign mul_sum    = {1'b0, work_hi_q} + {1'b0, mul_addend};

  // Divide step: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, oper_q};
  assign div_ge    = div_shift >= {1'b0, oper_q};

  // Fix-up values. A zero divisor leaves the remainder equal to |A|, so the
  // remainder sign fix-up also restores the original A for HI.
  logic [2*WIDTH-1:0] prod_mag, prod_fix, acc;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_mag = {work_hi_q, work_lo_q};
  assign prod_fix = neg_res_q ? -prod_mag : prod_mag;
  assign acc      = {hi_q, lo_q};
  assign quo_fix  = neg_res_q ? -work_lo_q : work_lo_q;
  assign rem_fix  = neg_rem_q ? -work_hi_q : work_hi_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    oper_d     = oper_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (!bus.op[3]) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            kind_d     = bus.op[2:1];
            div_zero_d = 1'b0;
            neg_res_d  = sign_a ^ sign_b;
            neg_rem_d  = sign_a;
            work_hi_d  = '0;
            if (bus.op[2:1] == K_DIV) begin
              oper_d    = abs_b;
              work_lo_d = abs_a;
            end else begin
              oper_d    = abs_a;
              work_lo_d = abs_b;
            end
          end else if (bus.op[2:1] == 2'b00) begin
            if (bus.op[0]) lo_d = bus.a;
            else           hi_d = bus.a;
            done_d     = 1'b1;
            div_zero_d = 1'b0;
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (kind_q == K_DIV) begin
            work_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], div_ge};
          end else begin
            work_hi_d = mul_sum[WIDTH:1];
            work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.abort) begin
          done_d = 1'b1;
          unique case (kind_q)
            K_DIV: begin
              hi_d = rem_fix;
              if (oper_q == '0) begin
                lo_d       = '1;
                div_zero_d = 1'b1;
              end else begin
                lo_d = quo_fix;
              end
            end
            K_MADD:  {hi_d, lo_d} = acc + prod_fix;
            K_MSUB:  {hi_d, lo_d} = acc - prod_fix;
            default: {hi_d, lo_d} = prod_fix;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kind_q     <= K_MUL;
      oper_q     <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      oper_q     <= oper_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table plus abort/reset/handshake sequences.
module tb_hilo_muldiv_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   lat;

  hilo_muldiv_if #(.WIDTH(32)) bus();

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges counted after the accept edge until done is seen; -1 if never.
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.abort = 1'b0;

    //           op     a             b             pre_hi        pre_lo        exp_hi        exp_lo        dz
    vecs[0]  = '{4'd0, 32'hFFFFFFFD, 32'd5,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{4'd0, 32'h80000000, 32'h80000000, 32'd0,        32'd0,        32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{4'd3, 32'd7,        32'd2,        32'd0,        32'd0,        32'd1,        32'd3,        1'b0};
    vecs[5]  = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd0,        32'd0,        32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        32'h80000000, 1'b0};
    vecs[7]  = '{4'd3, 32'h00001234, 32'd0,        32'd0,        32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[8]  = '{4'd2, 32'hFFFFFFF9, 32'd0,        32'd0,        32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{4'd5, 32'hFFFFFFFF, 32'd2,        32'd0,        32'h00000010, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[10] = '{4'd4, 32'hFFFFFFFD, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};
    vecs[11] = '{4'd7, 32'd1,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{4'd6, 32'hFFFFFFFE, 32'd3,        32'd0,        32'd0,        32'd0,        32'd6,        1'b0};
    vecs[13] = '{4'd3, 32'hFFFFFFFF, 32'h00000010, 32'd0,        32'd0,        32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[14] = '{4'd1, 32'd0,        32'h00001234, 32'h12345678, 32'h9ABCDEF0, 32'd0,        32'd0,        1'b0};

    #22;
    check("reset_hi",   {32'd0, bus.hi}, 64'd0);
    check("reset_lo",   {32'd0, bus.lo}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_dz",   {63'd0, bus.div_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(4'd8, vecs[i].pre_hi, 32'd0);
      check($sformatf("v%0d_mthi_done", i), {63'd0, bus.done}, 64'd1);
      check($sformatf("v%0d_mthi_busy", i), {63'd0, bus.busy}, 64'd0);
      issue(4'd9, vecs[i].pre_lo, 32'd0);
      check($sformatf("v%0d_pre_hilo", i), {bus.hi, bus.lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
      check($sformatf("v%0d_dz_cleared", i), {63'd0, bus.div_zero}, 64'd0);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {63'd0, bus.busy}, 64'd1);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("v%0d_dz", i), {63'd0, bus.div_zero}, {63'd0, vecs[i].exp_dz});
      check($sformatf("v%0d_busy_done", i), {63'd0, bus.busy}, 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
    end

    // Reserved op code: no busy, no done, HI/LO kept.
    issue(4'd8, 32'h0000AAAA, 32'd0);
    issue(4'd9, 32'h00005555, 32'd0);
    issue(4'd12, 32'hDEADBEEF, 32'd1);
    check("rsvd_busy", {63'd0, bus.busy}, 64'd0);
    check("rsvd_done", {63'd0, bus.done}, 64'd0);
    check("rsvd_hilo", {bus.hi, bus.lo}, {32'h0000AAAA, 32'h00005555});

    // Abort mid-MULT: sampled at edge 10, no done afterwards, HI/LO untouched.
    issue(4'd0, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    wait_done(lat);
    check("abort_no_done", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
    check("abort_hilo", {bus.hi, bus.lo}, {32'h0000AAAA, 32'h00005555});

    // Abort together with start in idle: start dropped.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", {63'd0, bus.busy}, 64'd0);
    wait_done(lat);
    check("abort_start_no_done", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);

    // Start while busy is ignored; the original DIVU completes unchanged.
    issue(4'd3, 32'd7, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", 64'(lat), 64'd29);
    check("busy_start_hilo", {bus.hi, bus.lo}, {32'd1, 32'd3});

    // Back-to-back: start issued in the done cycle is accepted.
    issue(4'd1, 32'd6, 32'd7);
    check("b2b_busy", {63'd0, bus.busy}, 64'd1);
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_hilo", {bus.hi, bus.lo}, {32'd0, 32'h0000002A});

    // Reset asserted mid-DIV clears everything immediately.
    issue(4'd8, 32'h00000055, 32'd0);
    issue(4'd2, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_done", {63'd0, bus.done}, 64'd0);
    check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 32'd6, 32'd7);
    wait_done(lat);
    check("post_rst_latency", 64'(lat), 64'd33);
    check("post_rst_hilo", {bus.hi, bus.lo}, {32'd0, 32'h0000002A});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
